cheat_code_player: RTL and testbench

//  Transmit side of the cheat-code event interface. On go_i, plays the full code as press/release pulses.

---
 rtl/cheat_pkg.sv | 48 ++++
 rtl/cheat_evt_decode.sv | 24 ++
 rtl/cheat_code_player.sv | 163 ++++++++++++++++
 tb/tb_cheat_code_player.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheat_pkg.sv
// Shared definitions for the cheat-code player and detector.
// Holds the key/event types and the 22-entry code ROM so both ends agree
// on the sequence: START, A, B, RIGHT, LEFT, RIGHT, LEFT, DOWN, DOWN, UP, UP,
// each key appearing as a press event followed by its release event.
package cheat_pkg;

  localparam int unsigned CODE_LEN  = 22;
  localparam int unsigned STEP_W    = 5;
  localparam int unsigned NUM_LINES = 14;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    A     = 3'd4,
    B     = 3'd5,
    START = 3'd6
  } key_e;

  // One event on the interface: which key, and whether it is the release.
  typedef struct packed {
    key_e key;
    logic is_release;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam evt_t CODE_ROM [CODE_LEN] = '{
    '{START, 1'b0}, '{START, 1'b1},
    '{A,     1'b0}, '{A,     1'b1},
    '{B,     1'b0}, '{B,     1'b1},
    '{RIGHT, 1'b0}, '{RIGHT, 1'b1},
    '{LEFT,  1'b0}, '{LEFT,  1'b1},
    '{RIGHT, 1'b0}, '{RIGHT, 1'b1},
    '{LEFT,  1'b0}, '{LEFT,  1'b1},
    '{DOWN,  1'b0}, '{DOWN,  1'b1},
    '{DOWN,  1'b0}, '{DOWN,  1'b1},
    '{UP,    1'b0}, '{UP,    1'b1},
    '{UP,    1'b0}, '{UP,    1'b1}
  };

endpackage

// File: rtl/cheat_evt_decode.sv
// Combinational event decoder: one evt_t plus a valid flag -> 14 event lines.
// Line index is {key, is_release}, so bit 2k is the press of key k and bit
// 2k+1 its release (UP=0/1, DOWN=2/3, LEFT=4/5, RIGHT=6/7, A=8/9, B=10/11,
// START=12/13). At most one line is ever high.
// Ports:
//   i_evt       in  evt_t  event to decode
//   i_valid     in  1      drive the line for i_evt; all zero when low
//   o_lines_c   out 14     decoded event lines (unregistered)
module cheat_evt_decode
  import cheat_pkg::*;
(
  input  evt_t                   i_evt,
  input  logic                   i_valid,
  output logic [NUM_LINES-1:0]   o_lines_c
);

  always_comb begin
    o_lines_c = '0;
    if (i_valid) begin
      o_lines_c[4'({i_evt.key, i_evt.is_release})] = 1'b1;
    end
  end

endmodule

// File: rtl/cheat_code_player.sv
// Transmit side of the cheat-code event interface. On go_i the full code is
// played from CODE_ROM as single-cycle press/release pulses, separated by
// GAP_CYCLES idle cycles. All outputs are registered from next-state values.
// Optional feature: define CHEAT_PLAYER_ABORT_EN to add abort_i, which
// cancels a playback in progress (returns to IDLE without done_o).
// Ports:
//   clk_i, reset_i (async, active high)
//   go_i       start request, sampled only in IDLE
//   abort_i    cancel playback (CHEAT_PLAYER_ABORT_EN builds only)
//   *_o / un*_o  press/release pulses for UP, DOWN, LEFT, RIGHT, A, B, START
//   busy_o     high while playback is in EMIT/GAP
//   done_o     one-cycle pulse after the final release
//   step_o     index of event emitted or awaited, 0 when not playing
module cheat_code_player
  import cheat_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              go_i,
`ifdef CHEAT_PLAYER_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              up_o,
  output logic              unup_o,
  output logic              down_o,
  output logic              undown_o,
  output logic              left_o,
  output logic              unleft_o,
  output logic              right_o,
  output logic              unright_o,
  output logic              a_o,
  output logic              una_o,
  output logic              b_o,
  output logic              unb_o,
  output logic              start_o,
  output logic              unstart_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_o
);

  localparam int unsigned GAP_W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CODE_LEN - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [STEP_W-1:0]      r_step;
  logic [STEP_W-1:0]      w_step_nxt;
  logic [GAP_W-1:0]       r_gap;
  logic [GAP_W-1:0]       w_gap_nxt;
  logic                   w_abort;
  logic [NUM_LINES-1:0]   w_lines_c;
  logic [NUM_LINES-1:0]   r_lines;
  logic                   r_busy;
  logic                   r_done;

`ifdef CHEAT_PLAYER_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // State, step and gap-counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Next-state logic. Abort takes priority over completing the last event.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_gap_nxt   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (go_i && !w_abort) begin
          w_state_nxt = ST_EMIT;
          w_step_nxt  = '0;
        end
      end
      ST_EMIT: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_step == LAST_STEP) begin
          w_state_nxt = ST_DONE;
        end else if (GAP_CYCLES != 0) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_W'(GAP_CYCLES - 1);
        end else begin
          w_step_nxt  = r_step + STEP_W'(1);
        end
      end
      ST_GAP: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap == '0) begin
          w_state_nxt = ST_EMIT;
          w_step_nxt  = r_step + STEP_W'(1);
        end else begin
          w_gap_nxt   = r_gap - GAP_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // step_o reads 0 whenever no playback is in progress.
    if (w_state_nxt == ST_IDLE || w_state_nxt == ST_DONE) begin
      w_step_nxt = '0;
    end
  end

  // Decode the event for the upcoming cycle so the lines can be registered.
  cheat_evt_decode u_decode (
    .i_evt     (CODE_ROM[w_step_nxt]),
    .i_valid   (w_state_nxt == ST_EMIT),
    .o_lines_c (w_lines_c)
  );

  // Output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lines <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_lines <= w_lines_c;
      r_busy  <= (w_state_nxt == ST_EMIT) || (w_state_nxt == ST_GAP);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign up_o      = r_lines[0];
  assign unup_o    = r_lines[1];
  assign down_o    = r_lines[2];
  assign undown_o  = r_lines[3];
  assign left_o    = r_lines[4];
  assign unleft_o  = r_lines[5];
  assign right_o   = r_lines[6];
  assign unright_o = r_lines[7];
  assign a_o       = r_lines[8];
  assign una_o     = r_lines[9];
  assign b_o       = r_lines[10];
  assign unb_o     = r_lines[11];
  assign start_o   = r_lines[12];
  assign unstart_o = r_lines[13];
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign step_o    = r_step;

endmodule

// File: tb/tb_cheat_code_player.sv
// Bench for cheat_code_player: two instances (GAP_CYCLES 0 and 3) checked
// every cycle against a cycle-count reference model of the playback timing.
module tb_cheat_code_player;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] go;
  logic [1:0] abort;

  wire [13:0] ev_g0, ev_g3;
  wire        busy_g0, busy_g3, done_g0, done_g3;
  wire [4:0]  step_g0, step_g3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_k [2];   // cycles since go accepted; 0 = idle

  // Key numbering for the bench: UP=0 DOWN=1 LEFT=2 RIGHT=3 A=4 B=5 START=6.
  int code_key [11] = '{6, 4, 5, 3, 2, 3, 2, 1, 1, 0, 0};

  always #5 clk = ~clk;

  cheat_code_player #(.GAP_CYCLES(0)) u_dut_g0 (
    .clk_i(clk), .reset_i(rst[0]), .go_i(go[0]),
`ifdef CHEAT_PLAYER_ABORT_EN
    .abort_i(abort[0]),
`endif
    .up_o(ev_g0[13]), .unup_o(ev_g0[12]), .down_o(ev_g0[11]), .undown_o(ev_g0[10]),
    .left_o(ev_g0[9]), .unleft_o(ev_g0[8]), .right_o(ev_g0[7]), .unright_o(ev_g0[6]),
    .a_o(ev_g0[5]), .una_o(ev_g0[4]), .b_o(ev_g0[3]), .unb_o(ev_g0[2]),
    .start_o(ev_g0[1]), .unstart_o(ev_g0[0]),
    .busy_o(busy_g0), .done_o(done_g0), .step_o(step_g0)
  );

  cheat_code_player #(.GAP_CYCLES(3)) u_dut_g3 (
    .clk_i(clk), .reset_i(rst[1]), .go_i(go[1]),
`ifdef CHEAT_PLAYER_ABORT_EN
    .abort_i(abort[1]),
`endif
    .up_o(ev_g3[13]), .unup_o(ev_g3[12]), .down_o(ev_g3[11]), .undown_o(ev_g3[10]),
    .left_o(ev_g3[9]), .unleft_o(ev_g3[8]), .right_o(ev_g3[7]), .unright_o(ev_g3[6]),
    .a_o(ev_g3[5]), .una_o(ev_g3[4]), .b_o(ev_g3[3]), .unb_o(ev_g3[2]),
    .start_o(ev_g3[1]), .unstart_o(ev_g3[0]),
    .busy_o(busy_g3), .done_o(done_g3), .step_o(step_g3)
  );

  function automatic int gap_of(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int len_of(int d);
    return 22 + 21 * gap_of(d);
  endfunction

  function automatic logic [20:0] obs(int d);
    return (d == 0) ? {ev_g0, busy_g0, done_g0, step_g0} : {ev_g3, busy_g3, done_g3, step_g3};
  endfunction

  function automatic logic [13:0] ev_of(int d);
    return (d == 0) ? ev_g0 : ev_g3;
  endfunction

  // Expected {lines, busy, done, step} from the cycle count since go.
  function automatic logic [20:0] expect_of(int d);
    int g, len, k, p, idx, key;
    logic [13:0] ev;
    logic        b, dn;
    logic [4:0]  st;
    g = gap_of(d); len = len_of(d); k = m_k[d];
    ev = '0; b = 1'b0; dn = 1'b0; st = '0;
    if (k >= 1 && k <= len) begin
      p   = k - 1;
      idx = p / (g + 1);
      b   = 1'b1;
      st  = 5'(idx);
      if (p % (g + 1) == 0) begin
        key = code_key[idx / 2];
        ev[13 - 2 * key - (idx % 2)] = 1'b1;
      end
    end else if (k == len + 1) begin
      dn = 1'b1;
    end
    return {ev, b, dn, st};
  endfunction

  // Advance one clock; the model samples the same inputs the DUTs see.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst[d])                      m_k[d] = 0;
      else if (m_k[d] == 0)            m_k[d] = (go[d] && !abort[d]) ? 1 : 0;
      else if (m_k[d] == len_of(d) + 1) m_k[d] = 0;
      else if (abort[d])               m_k[d] = 0;
      else                             m_k[d] = m_k[d] + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Per-cycle invariants on both instances.
  always @(negedge clk) begin
    if (!$onehot0(ev_g0) || !$onehot0(ev_g3)) begin
      errors++; $display("FAIL onehot0 cyc%0d got %h/%h want onehot0", cyc, ev_g0, ev_g3);
    end
    checks++;
    if (step_g0 > 5'd21 || step_g3 > 5'd21) begin
      errors++; $display("FAIL step_range cyc%0d got %0d/%0d want <=21", cyc, step_g0, step_g3);
    end
    checks++;
    if ((busy_g0 && done_g0) || (busy_g3 && done_g3)) begin
      errors++; $display("FAIL busy_done cyc%0d got both high want exclusive", cyc);
    end
    checks++;
  end

  task automatic test_reset();
    rst = 2'b11; go = 2'b00; abort = 2'b00;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      if (obs(d) !== 21'h0) begin
        errors++; $display("FAIL reset dut%0d got %h want %h", d, obs(d), 21'h0);
      end
      checks++;
    end
    rst = 2'b00;
    tick();
  endtask

  // Full playback with no gap: start_o at cycle 1, done_o at cycle 23.
  task automatic test_gap0_sequence();
    int dones, first_done;
    dones = 0; first_done = -1;
    go[0] = 1'b1; tick(); go[0] = 1'b0;
    if (ev_g0[1] !== 1'b1 || busy_g0 !== 1'b1) begin
      errors++; $display("FAIL gap0_first got start=%b busy=%b want 1 1", ev_g0[1], busy_g0);
    end
    checks++;
    for (int c = 1; c <= 26; c++) begin
      if (obs(0) !== expect_of(0)) begin
        errors++; $display("FAIL gap0_seq cyc%0d got %h want %h", c, obs(0), expect_of(0));
      end
      checks++;
      if (done_g0) begin dones++; if (first_done < 0) first_done = c; end
      tick();
    end
    if (dones != 1 || first_done != 23) begin
      errors++; $display("FAIL gap0_done got %0d pulses at %0d want 1 at 23", dones, first_done);
    end
    checks++;
  endtask

  // GAP_CYCLES=3: 22 pulses, first to last spans 85 cycles.
  task automatic test_gap3_sequence();
    int first, last, pulses;
    first = -1; last = -1; pulses = 0;
    go[1] = 1'b1; tick(); go[1] = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      if (obs(1) !== expect_of(1)) begin
        errors++; $display("FAIL gap3_seq cyc%0d got %h want %h", c, obs(1), expect_of(1));
      end
      checks++;
      if (ev_g3 != 14'h0) begin pulses++; if (first < 0) first = c; last = c; end
      tick();
    end
    if (pulses != 22 || (last - first + 1) != 85) begin
      errors++; $display("FAIL gap3_span got %0d pulses span %0d want 22 span 85", pulses, last - first + 1);
    end
    checks++;
  endtask

  // go re-pulsed while busy (incl. step 5) and in DONE: no effect.
  task automatic test_go_ignored();
    int dones;
    dones = 0;
    go[0] = 1'b1; tick(); go[0] = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      go[0] = (c == 6 || c == 23) ? 1'b1 : 1'(($urandom_range(0, 3) == 0) && c < 22);
      if (obs(0) !== expect_of(0)) begin
        errors++; $display("FAIL go_ignored cyc%0d got %h want %h", c, obs(0), expect_of(0));
      end
      checks++;
      if (done_g0) dones++;
      tick();
      go[0] = 1'b0;
    end
    if (dones != 1) begin
      errors++; $display("FAIL go_ignored_done got %0d want 1", dones);
    end
    checks++;
    tick(); tick();
  endtask

  // Async reset at step 9, outputs clear before the next edge, then restart.
  task automatic test_reset_mid();
    go[0] = 1'b1; tick(); go[0] = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    if (step_g0 !== 5'd9) begin
      errors++; $display("FAIL reset_mid_step got %0d want 9", step_g0);
    end
    checks++;
    #2 rst[0] = 1'b1; m_k[0] = 0;
    #1;
    if (obs(0) !== 21'h0) begin
      errors++; $display("FAIL reset_mid_async got %h want %h", obs(0), 21'h0);
    end
    checks++;
    tick(); rst[0] = 1'b0; tick();
    go[0] = 1'b1; tick(); go[0] = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (obs(0) !== expect_of(0)) begin
        errors++; $display("FAIL reset_restart cyc%0d got %h want %h", c, obs(0), expect_of(0));
      end
      checks++;
      tick();
    end
  endtask

  // go held high: back-to-back playbacks with one idle cycle after done.
  task automatic test_back_to_back();
    go[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (obs(0) !== expect_of(0)) begin
        errors++; $display("FAIL back_to_back cyc%0d got %h want %h", c, obs(0), expect_of(0));
      end
      checks++;
    end
    go[0] = 1'b0;
    for (int c = 0; c < 30; c++) tick();
  endtask

  // Random go (and abort where built) on both instances.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        go[d] = 1'($urandom_range(0, 9) == 0);
`ifdef CHEAT_PLAYER_ABORT_EN
        abort[d] = 1'($urandom_range(0, 39) == 0);
`endif
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        if (obs(d) !== expect_of(d)) begin
          errors++; $display("FAIL random dut%0d cyc%0d got %h want %h", d, cyc, obs(d), expect_of(d));
        end
        checks++;
      end
    end
    go = 2'b00; abort = 2'b00;
    for (int c = 0; c < 110; c++) tick();
  endtask

`ifdef CHEAT_PLAYER_ABORT_EN
  // Abort at step 12, then a fresh full playback.
  task automatic test_abort();
    int dones, pulses;
    dones = 0; pulses = 0;
    go[1] = 1'b1; abort[1] = 1'b1; tick(); go[1] = 1'b0; abort[1] = 1'b0;
    if (busy_g3 !== 1'b0) begin
      errors++; $display("FAIL abort_with_go got busy=%b want 0", busy_g3);
    end
    checks++;
    go[1] = 1'b1; tick(); go[1] = 1'b0;
    for (int c = 1; c < 49; c++) tick();
    if (step_g3 !== 5'd12) begin
      errors++; $display("FAIL abort_step got %0d want 12", step_g3);
    end
    checks++;
    abort[1] = 1'b1; tick(); abort[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (obs(1) !== 21'h0) begin
        errors++; $display("FAIL abort_idle cyc%0d got %h want %h", c, obs(1), 21'h0);
      end
      checks++;
      tick();
    end
    go[1] = 1'b1; tick(); go[1] = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      if (ev_of(1) != 14'h0) pulses++;
      if (done_g3) dones++;
      tick();
    end
    if (pulses != 22 || dones != 1) begin
      errors++; $display("FAIL abort_replay got %0d pulses %0d dones want 22 1", pulses, dones);
    end
    checks++;
  endtask
`endif

  initial begin
    m_k[0] = 0; m_k[1] = 0;
    rst = 2'b11; go = 2'b00; abort = 2'b00;
    test_reset();
    test_gap0_sequence();
    test_gap3_sequence();
    test_go_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef CHEAT_PLAYER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
